// File: rtl/vc_test_rand_delay_source.sv
// Val/rdy message source: replays a preloaded message memory with optional
// LFSR-driven idle gaps between messages and optional wrap-around looping.
module vc_test_rand_delay_source #(
    parameter int unsigned p_msg_nbits   = 32,
    parameter int unsigned p_num_msgs    = 1024,
    parameter int unsigned p_max_delay   = 0,
    parameter logic [15:0] p_lfsr_seed   = 16'hACE1,
    localparam int unsigned c_index_nbits =
        ($clog2(p_num_msgs) > 1) ? $clog2(p_num_msgs) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_en,
    input  logic [c_index_nbits-1:0] ld_addr,
    input  logic [p_msg_nbits-1:0]   ld_msg,
    input  logic [c_index_nbits:0]   num_msgs,
    input  logic                     loop,
    input  logic                     start,
    output logic                     val,
    input  logic                     rdy,
    output logic [p_msg_nbits-1:0]   msg,
    output logic                     done,
    output logic [31:0]              count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] c_taps     = 16'hB400;
    localparam logic [15:0] c_dly_mask = 16'(p_max_delay);

    logic [p_msg_nbits-1:0] mem [p_num_msgs];

    state_t                   state_r, state_n;
    logic [c_index_nbits-1:0] index_r, index_n;
    logic [31:0]              count_r, count_n;
    logic [15:0]              dly_r, dly_n;
    logic [15:0]              lfsr_r, lfsr_n;
    logic [c_index_nbits:0]   n_r, n_n;
    logic                     loop_r, loop_n;
    logic                     val_r, val_n;
    logic                     done_r, done_n;

    logic [15:0] lfsr_adv;
    logic [15:0] dly_new;
    logic        go;
    logic        idle_or_done;
    logic        last;

    // Shared decode: LFSR successor, candidate delay, handshake, last-index test.
    always_comb begin
        lfsr_adv     = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? c_taps : 16'h0000);
        dly_new      = lfsr_adv & c_dly_mask;
        go           = val_r && rdy;
        idle_or_done = (state_r == IDLE) || (state_r == DONE);
        last         = ({1'b0, index_r} == (n_r - (c_index_nbits + 1)'(1)));
    end

    // Next-state and next-register values for the pass controller.
    always_comb begin
        state_n = state_r;
        index_n = index_r;
        count_n = count_r;
        dly_n   = dly_r;
        lfsr_n  = lfsr_r;
        n_n     = n_r;
        loop_n  = loop_r;
        unique case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    n_n     = num_msgs;
                    loop_n  = loop;
                    index_n = '0;
                    count_n = '0;
                    lfsr_n  = lfsr_adv;
                    if (num_msgs == '0) begin
                        state_n = DONE;
                    end else begin
                        dly_n   = dly_new;
                        state_n = (dly_new == '0) ? SEND : DELAY;
                    end
                end
            end
            DELAY: begin
                dly_n = dly_r - 16'd1;
                if (dly_r == 16'd1) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                if (go) begin
                    count_n = count_r + 32'd1;
                    lfsr_n  = lfsr_adv;
                    if (last && !loop_r) begin
                        state_n = DONE;
                    end else begin
                        index_n = last ? '0 : index_r + c_index_nbits'(1);
                        dly_n   = dly_new;
                        state_n = (dly_new == '0) ? SEND : DELAY;
                    end
                end
            end
            default: ;
        endcase
        // val/done are decoded from the next state so they leave as flops
        val_n  = (state_n == SEND);
        done_n = (state_n == DONE);
    end

    // Controller registers; async reset drops any message in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            index_r <= '0;
            count_r <= '0;
            dly_r   <= '0;
            lfsr_r  <= p_lfsr_seed;
            n_r     <= '0;
            loop_r  <= 1'b0;
            val_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            index_r <= index_n;
            count_r <= count_n;
            dly_r   <= dly_n;
            lfsr_r  <= lfsr_n;
            n_r     <= n_n;
            loop_r  <= loop_n;
            val_r   <= val_n;
            done_r  <= done_n;
        end
    end

    // Message memory write; not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (ld_en && idle_or_done) begin
            mem[ld_addr] <= ld_msg;
        end
    end

    assign msg   = mem[index_r];
    assign val   = val_r;
    assign done  = done_r;
    assign count = count_r;

    a_no_x: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({val_r, rdy}));

    a_num_msgs: assert property (@(posedge clk) disable iff (!reset)
        (start && idle_or_done) |-> (32'(num_msgs) <= 32'(p_num_msgs)));

endmodule
